// File: rtl/ahb_dual_arbiter.sv
// ahb_dual_arbiter: two AHB-Lite masters sharing one slave, one-entry request buffer per master, round-robin grant.
// Optional build macro ARB_HMASTLOCK_EN: a locked transfer keeps the grant until its owner unlocks or goes IDLE.
module ahb_dual_arbiter #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [1:0]        m0_htrans,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic              m0_hexcl,
  input  logic [W_DATA-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic              m0_hexokay,
  output logic [W_DATA-1:0] m0_hrdata,
  input  logic [W_ADDR-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [1:0]        m1_htrans,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic              m1_hexcl,
  input  logic [W_DATA-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic              m1_hexokay,
  output logic [W_DATA-1:0] m1_hrdata,
  output logic [W_ADDR-1:0] ahbls_haddr,
  output logic              ahbls_hwrite,
  output logic [1:0]        ahbls_htrans,
  output logic [2:0]        ahbls_hsize,
  output logic [2:0]        ahbls_hburst,
  output logic [3:0]        ahbls_hprot,
  output logic              ahbls_hmastlock,
  output logic              ahbls_hexcl,
  output logic [W_DATA-1:0] ahbls_hwdata,
  output logic              ahbls_hready,
  output logic [7:0]        ahbls_hmaster,
  input  logic              ahbls_hready_resp,
  input  logic              ahbls_hresp,
  input  logic              ahbls_hexokay,
  input  logic [W_DATA-1:0] ahbls_hrdata
);

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              mastlock;
    logic              excl;
  } req_t;

  req_t       w_liveReq   [2];
  req_t       w_candReq   [2];
  logic [1:0] w_candTrans [2];
  logic [1:0] w_htrans    [2];
  logic [1:0] w_live;
  logic [1:0] w_cand;
  logic [1:0] w_elig;
  logic [1:0] w_hready;
  logic       w_issue;
  logic       w_grant;
  logic       r_ptr;
  logic       r_hmaster;
  logic       r_dpValid;
  logic       r_dpOwner;

  assign w_liveReq[0] = '{m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock, m0_hexcl};
  assign w_liveReq[1] = '{m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock, m1_hexcl};
  assign w_htrans[0]  = m0_htrans;
  assign w_htrans[1]  = m1_htrans;

  for (genvar g = 0; g < 2; g++) begin : g_master
    req_t r_buf;
    logic r_bufValid;

    // A full buffer stalls its master; otherwise the master follows the slave only during its own data phase.
    assign w_hready[g]    = ~r_bufValid & (~(r_dpValid & (r_dpOwner == 1'(g))) | ahbls_hready_resp);
    assign w_live[g]      = w_htrans[g][1] & w_hready[g];
    assign w_cand[g]      = r_bufValid | w_live[g];
    assign w_candReq[g]   = r_bufValid ? r_buf : w_liveReq[g];
    assign w_candTrans[g] = r_bufValid ? 2'b10 : w_htrans[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_bufValid <= 1'b0;
        r_buf      <= '0;
      end else if (w_issue && (w_grant == 1'(g))) begin
        r_bufValid <= 1'b0;
      end else if (w_live[g]) begin
        r_bufValid <= 1'b1;
        r_buf      <= w_liveReq[g];
      end
    end
  end

`ifdef ARB_HMASTLOCK_EN
  logic r_locked;
  logic r_lockOwner;

  assign w_elig = r_locked ? (w_cand & (r_lockOwner ? 2'b10 : 2'b01)) : w_cand;

  // The lock follows every issued transfer and also drops when its owner presents IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked    <= 1'b0;
      r_lockOwner <= 1'b0;
    end else if (w_issue) begin
      r_locked    <= w_candReq[w_grant].mastlock;
      r_lockOwner <= w_grant;
    end else if (r_locked && (w_htrans[r_lockOwner] == 2'b00) && w_hready[r_lockOwner]) begin
      r_locked <= 1'b0;
    end
  end
`else
  assign w_elig = w_cand;
`endif

  assign w_grant = (w_elig == 2'b11) ? r_ptr : w_elig[1];
  assign w_issue = ~rst & ahbls_hready_resp & (|w_elig);

  // The pointer names the master that wins the next tie, i.e. the one not granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_hmaster <= 1'b0;
      r_dpValid <= 1'b0;
      r_dpOwner <= 1'b0;
    end else if (w_issue) begin
      r_ptr     <= ~w_grant;
      r_hmaster <= w_grant;
      r_dpValid <= 1'b1;
      r_dpOwner <= w_grant;
    end else if (ahbls_hready_resp) begin
      r_dpValid <= 1'b0;
    end
  end

  assign ahbls_haddr     = w_candReq[w_grant].addr;
  assign ahbls_hwrite    = w_candReq[w_grant].write;
  assign ahbls_hsize     = w_candReq[w_grant].size;
  assign ahbls_hburst    = w_candReq[w_grant].burst;
  assign ahbls_hprot     = w_candReq[w_grant].prot;
  assign ahbls_hmastlock = w_candReq[w_grant].mastlock;
  assign ahbls_hexcl     = w_candReq[w_grant].excl;
  assign ahbls_htrans    = w_issue ? w_candTrans[w_grant] : 2'b00;
  assign ahbls_hmaster   = {7'd0, (w_issue ? w_grant : r_hmaster)};
  assign ahbls_hready    = ahbls_hready_resp;
  assign ahbls_hwdata    = r_dpOwner ? m1_hwdata : m0_hwdata;

  assign m0_hready  = w_hready[0];
  assign m1_hready  = w_hready[1];
  assign m0_hrdata  = (r_dpValid && !r_dpOwner) ? ahbls_hrdata : '0;
  assign m1_hrdata  = (r_dpValid &&  r_dpOwner) ? ahbls_hrdata : '0;
  assign m0_hresp   = r_dpValid & ~r_dpOwner & ahbls_hresp;
  assign m1_hresp   = r_dpValid &  r_dpOwner & ahbls_hresp;
  assign m0_hexokay = (r_dpValid && !r_dpOwner) ? ahbls_hexokay : 1'b1;
  assign m1_hexokay = (r_dpValid &&  r_dpOwner) ? ahbls_hexokay : 1'b1;

endmodule

// File: tb/tb_ahb_dual_arbiter.sv
// tb_ahb_dual_arbiter: directed scenarios followed by random traffic, checked against a transaction-level model.
// Build with ARB_HMASTLOCK_EN defined to expect locked sequences to hold the grant.
module tb_ahb_dual_arbiter;
`ifdef ARB_HMASTLOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  mTrans [2];
  logic [31:0] mAddr  [2];
  logic        mWrite [2];
  logic        mLock  [2];
  logic        mExcl  [2];
  logic [31:0] mWdata [2];

  logic        slvReady, slvResp, slvExokay;
  logic [31:0] slvRdata;

  logic        m0Hready, m0Hresp, m0Hexokay, m1Hready, m1Hresp, m1Hexokay;
  logic [31:0] m0Hrdata, m1Hrdata;
  logic [31:0] sHaddr, sHwdata;
  logic        sHwrite, sHmastlock, sHexcl, sHready;
  logic [1:0]  sHtrans;
  logic [2:0]  sHsize, sHburst;
  logic [3:0]  sHprot;
  logic [7:0]  sHmaster;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted-but-not-issued request per master, fairness and data-phase owner.
  bit          pend  [2];
  logic [31:0] pAddr [2];
  logic        pWrite[2], pLock[2], pExcl[2];
  bit          held  [2];
  int          lastGrant, lastHm, dpO, lockOwner;
  bit          dpV, locked;

  always #5 clk = ~clk;

  ahb_dual_arbiter #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst),
    .m0_haddr(mAddr[0]), .m0_hwrite(mWrite[0]), .m0_htrans(mTrans[0]), .m0_hsize(3'b010),
    .m0_hburst(3'b000), .m0_hprot(4'h3), .m0_hmastlock(mLock[0]), .m0_hexcl(mExcl[0]),
    .m0_hwdata(mWdata[0]), .m0_hready(m0Hready), .m0_hresp(m0Hresp), .m0_hexokay(m0Hexokay),
    .m0_hrdata(m0Hrdata),
    .m1_haddr(mAddr[1]), .m1_hwrite(mWrite[1]), .m1_htrans(mTrans[1]), .m1_hsize(3'b010),
    .m1_hburst(3'b000), .m1_hprot(4'h3), .m1_hmastlock(mLock[1]), .m1_hexcl(mExcl[1]),
    .m1_hwdata(mWdata[1]), .m1_hready(m1Hready), .m1_hresp(m1Hresp), .m1_hexokay(m1Hexokay),
    .m1_hrdata(m1Hrdata),
    .ahbls_haddr(sHaddr), .ahbls_hwrite(sHwrite), .ahbls_htrans(sHtrans), .ahbls_hsize(sHsize),
    .ahbls_hburst(sHburst), .ahbls_hprot(sHprot), .ahbls_hmastlock(sHmastlock), .ahbls_hexcl(sHexcl),
    .ahbls_hwdata(sHwdata), .ahbls_hready(sHready), .ahbls_hmaster(sHmaster),
    .ahbls_hready_resp(slvReady), .ahbls_hresp(slvResp), .ahbls_hexokay(slvExokay),
    .ahbls_hrdata(slvRdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int n = 0; n < 2; n++) begin
      pend[n]   = 1'b0;
      held[n]   = 1'b0;
      mTrans[n] = 2'b00;
      mLock[n]  = 1'b0;
    end
    lastGrant = 1;
    lastHm    = 0;
    dpV       = 1'b0;
    dpO       = 0;
    locked    = 1'b0;
    lockOwner = 0;
  endtask

  // Advance to just after the rising edge and put every idle master and the slave into a default state.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (!held[n]) begin
        mTrans[n] = 2'b00;
        mAddr[n]  = $urandom;
        mWrite[n] = 1'b0;
        mLock[n]  = 1'b0;
        mExcl[n]  = 1'b0;
      end
      mWdata[n] = $urandom;
    end
    slvReady  = 1'b1;
    slvRdata  = $urandom;
    slvResp   = 1'($urandom_range(0, 1));
    slvExokay = 1'($urandom_range(0, 1));
  endtask

  // A master still waiting on a stalled address phase must keep it, so new requests are ignored then.
  task automatic setMaster(input int n, input logic [31:0] addr, input logic wr, input logic lk, input logic ex);
    if (!held[n]) begin
      mTrans[n] = 2'b10;
      mAddr[n]  = addr;
      mWrite[n] = wr;
      mLock[n]  = lk;
      mExcl[n]  = ex;
    end
  endtask

  // Sample on the falling edge, compare against the model, then advance the model past the next rising edge.
  task automatic checkOutput();
    logic        expRdy[2], obsRdy[2], obsResp[2], obsExok[2];
    logic [31:0] obsRdata[2];
    logic        acc[2], cand[2], elig[2];
    logic [31:0] cAddr[2];
    logic        cWrite[2], cLock[2], cExcl[2];
    bit          owns, issued;
    int          win;
    @(negedge clk);
    obsRdy[0] = m0Hready;   obsRdy[1] = m1Hready;
    obsResp[0] = m0Hresp;   obsResp[1] = m1Hresp;
    obsExok[0] = m0Hexokay; obsExok[1] = m1Hexokay;
    obsRdata[0] = m0Hrdata; obsRdata[1] = m1Hrdata;
    if (rst) begin
      chk("rst_htrans", sHtrans, 2'b00);
      chk("rst_hmaster", sHmaster, 8'd0);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("rst_m%0d_hready", n), obsRdy[n], 1'b1);
        chk($sformatf("rst_m%0d_hresp", n), obsResp[n], 1'b0);
        chk($sformatf("rst_m%0d_hexokay", n), obsExok[n], 1'b1);
        chk($sformatf("rst_m%0d_hrdata", n), obsRdata[n], 32'd0);
      end
      modelReset();
      return;
    end
    chk("hready_loop", sHready, slvReady);
    for (int n = 0; n < 2; n++) begin
      owns      = dpV && (dpO == n);
      expRdy[n] = pend[n] ? 1'b0 : (owns ? slvReady : 1'b1);
      chk($sformatf("m%0d_hready", n), obsRdy[n], expRdy[n]);
      chk($sformatf("m%0d_hrdata", n), obsRdata[n], owns ? slvRdata : 32'd0);
      chk($sformatf("m%0d_hresp", n), obsResp[n], owns ? slvResp : 1'b0);
      chk($sformatf("m%0d_hexokay", n), obsExok[n], owns ? slvExokay : 1'b1);
    end
    if (dpV) chk("hwdata", sHwdata, mWdata[dpO]);
    for (int n = 0; n < 2; n++) begin
      acc[n]    = mTrans[n][1] && expRdy[n];
      cand[n]   = pend[n] || acc[n];
      cAddr[n]  = pend[n] ? pAddr[n]  : mAddr[n];
      cWrite[n] = pend[n] ? pWrite[n] : mWrite[n];
      cLock[n]  = pend[n] ? pLock[n]  : mLock[n];
      cExcl[n]  = pend[n] ? pExcl[n]  : mExcl[n];
      elig[n]   = cand[n] && !(locked && (lockOwner != n));
    end
    issued = slvReady && (elig[0] || elig[1]);
    win = 0;
    if (issued) begin
      win = (elig[0] && elig[1]) ? (1 - lastGrant) : (elig[0] ? 0 : 1);
      chk("htrans_issue", sHtrans, 2'b10);
      chk("hmaster", sHmaster, win);
      chk("haddr", sHaddr, cAddr[win]);
      chk("hwrite", sHwrite, cWrite[win]);
      chk("hmastlock", sHmastlock, cLock[win]);
      chk("hexcl", sHexcl, cExcl[win]);
      chk("hsize", sHsize, 3'b010);
      chk("hburst", sHburst, 3'b000);
      chk("hprot", sHprot, 4'h3);
      lastGrant = win;
      lastHm    = win;
      dpV       = 1'b1;
      dpO       = win;
      if (LOCK_EN) begin
        locked    = cLock[win];
        lockOwner = win;
      end
    end else begin
      chk("htrans_idle", sHtrans, 2'b00);
      chk("hmaster_hold", sHmaster, lastHm);
      if (slvReady) dpV = 1'b0;
      if (locked && (mTrans[lockOwner] == 2'b00) && expRdy[lockOwner]) locked = 1'b0;
    end
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        pAddr[n]  = mAddr[n];
        pWrite[n] = mWrite[n];
        pLock[n]  = mLock[n];
        pExcl[n]  = mExcl[n];
      end
      pend[n] = cand[n] && !(issued && (win == n));
      held[n] = mTrans[n][1] && !expRdy[n];
    end
  endtask

  initial begin
    logic [31:0] rd;
    for (int n = 0; n < 2; n++) begin
      mAddr[n] = '0; mWrite[n] = 1'b0; mExcl[n] = 1'b0; mWdata[n] = '0;
    end
    slvReady = 1'b1; slvResp = 1'b0; slvExokay = 1'b1; slvRdata = '0;
    modelReset();

    // Reset state, then one quiet cycle.
    applyStimulus(); checkOutput();
    applyStimulus(); checkOutput();
    applyStimulus(); rst = 1'b0; checkOutput();

    // Simultaneous reads: m0 wins the first tie, m1 is buffered then issued.
    applyStimulus(); setMaster(0, 32'h100, 0, 0, 0); setMaster(1, 32'h200, 0, 0, 0); checkOutput();
    chk("r029_hmaster_c0", sHmaster, 8'd0);
    chk("r029_haddr_c0", sHaddr, 32'h100);
    applyStimulus(); rd = slvRdata; checkOutput();
    chk("r029_m1_hready_c1", m1Hready, 1'b0);
    chk("r029_hmaster_c1", sHmaster, 8'd1);
    chk("r029_haddr_c1", sHaddr, 32'h200);
    chk("r029_m0_hrdata", m0Hrdata, rd);
    applyStimulus(); rd = slvRdata; checkOutput();
    chk("r029_m1_hrdata", m1Hrdata, rd);
    chk("r029_m0_hrdata_zero", m0Hrdata, 32'd0);

    // m0 streams reads; m1's single request must get in on the second slave-ready cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      setMaster(0, 32'h1000 + 32'(i * 4), 0, 0, 0);
      if (i == 1) setMaster(1, 32'h600, 0, 0, 0);
      checkOutput();
      if (i == 1) begin
        chk("r030_hmaster", sHmaster, 8'd1);
        chk("r030_haddr", sHaddr, 32'h600);
      end
    end
    for (int i = 0; i < 3; i++) begin applyStimulus(); checkOutput(); end

    // m1 write with the slave stalling three cycles.
    applyStimulus(); setMaster(1, 32'h40, 1, 0, 0); checkOutput();
    chk("r031_hmaster", sHmaster, 8'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(); slvReady = 1'b0; mWdata[1] = 32'hDEADBEEF; checkOutput();
      chk("r031_hwdata_wait", sHwdata, 32'hDEADBEEF);
      chk("r031_m1_hready", m1Hready, 1'b0);
      chk("r031_m0_hready", m0Hready, 1'b1);
    end
    applyStimulus(); mWdata[1] = 32'hDEADBEEF; checkOutput();
    chk("r031_hwdata_last", sHwdata, 32'hDEADBEEF);

    // Exclusive read by m0, failing exclusive write by m1.
    applyStimulus(); setMaster(0, 32'h80, 0, 0, 1); checkOutput();
    applyStimulus(); setMaster(1, 32'h84, 1, 0, 1); slvExokay = 1'b1; checkOutput();
    chk("r032_m0_exok", m0Hexokay, 1'b1);
    chk("r032_hmaster", sHmaster, 8'd1);
    applyStimulus(); slvExokay = 1'b0; checkOutput();
    chk("r032_m1_exfail", m1Hexokay, 1'b0);
    chk("r032_m0_exok_hold", m0Hexokay, 1'b1);
    applyStimulus(); checkOutput();

    // Reset while m1 sits in its buffer.
    applyStimulus(); setMaster(0, 32'h900, 0, 0, 0); setMaster(1, 32'hA00, 0, 0, 0); checkOutput();
    chk("r033_hmaster", sHmaster, 8'd0);
    applyStimulus(); slvReady = 1'b0; checkOutput();
    chk("r033_m1_buffered", m1Hready, 1'b0);
    applyStimulus(); rst = 1'b1; checkOutput();
    applyStimulus(); rst = 1'b0; checkOutput();
    chk("r033_htrans", sHtrans, 2'b00);
    chk("r033_m1_hready", m1Hready, 1'b1);

    // Locked read then write by m0 with m1 contending.
    applyStimulus(); setMaster(0, 32'h300, 0, 1, 0); checkOutput();
    applyStimulus(); setMaster(0, 32'h304, 1, 1, 0); setMaster(1, 32'h500, 0, 0, 0); checkOutput();
    chk("r034_hmaster_c1", sHmaster, LOCK_EN ? 8'd0 : 8'd1);
    applyStimulus(); checkOutput();
    chk("r034_htrans_c2", sHtrans, LOCK_EN ? 2'b00 : 2'b10);
    applyStimulus(); checkOutput();
    chk("r034_htrans_c3", sHtrans, LOCK_EN ? 2'b10 : 2'b00);
    chk("r034_hmaster_c3", sHmaster, LOCK_EN ? 8'd1 : 8'd0);
    applyStimulus(); checkOutput();

    // Random traffic with a stalling slave and one reset pulse.
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      rst = (i == 200);
      slvReady = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 1) == 1)
          setMaster(n, $urandom & 32'h0000_FFFC, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
